// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths:
// FSM state encoding, parity modes and the default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 50 MHz system clock at 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// A synchronous clear restarts the period from zero.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clear || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // Must not depend on clear: the transmitter derives clear from bit_done
  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the transmit FIFO and serializes them
// as start bit, LSB-first data, optional parity and 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic             tx,
  output logic             busy
);

  localparam int BIT_W = $clog2(WIDTH + STOP_BITS);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  uart_state_t      state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [BIT_W-1:0] bit_cnt, bit_n;
  logic             par_reg, par_n;
  logic             tx_n, busy_n;
  logic             bit_done, last_stop, baud_clear;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  assign last_stop  = (state == S_STOP) && (bit_cnt == LAST_STOP) && bit_done;
  assign fifo_read  = rst && !fifo_empty && ((state == S_IDLE) || last_stop);
  assign baud_clear = fifo_read || (state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_reg   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_n;
      par_reg   <= par_n;
      tx        <= tx_n;
      busy      <= busy_n;
    end
  end

  // A pop takes priority in every state, which gives back-to-back frames for free.
  // Parity is settled at pop time so the shifting register never feeds it.
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    bit_n   = bit_cnt;
    par_n   = par_reg;
    tx_n    = tx;
    busy_n  = busy;
    if (fifo_read) begin
      shift_n = fifo_data;
      par_n   = parity_bit(^fifo_data, PARITY);
      bit_n   = '0;
      state_n = S_START;
      tx_n    = 1'b0;
      busy_n  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx_n   = 1'b1;
          busy_n = 1'b0;
        end
        S_START: begin
          if (bit_done) begin
            state_n = S_DATA;
            tx_n    = shift_reg[0];
            bit_n   = '0;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            if (bit_cnt == LAST_DATA) begin
              bit_n = '0;
              if (PARITY != PARITY_NONE) begin
                state_n = S_PARITY;
                tx_n    = par_reg;
              end else begin
                state_n = S_STOP;
                tx_n    = 1'b1;
              end
            end else begin
              shift_n = shift_reg >> 1;
              tx_n    = shift_n[0];
              bit_n   = bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
            bit_n   = '0;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (bit_cnt == LAST_STOP) begin
              state_n = S_IDLE;
              busy_n  = 1'b0;
              tx_n    = 1'b1;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

endmodule
